// File: rtl/ntt_stream_adapter.sv
// Purpose: serial-to-parallel front end and parallel-to-serial back end around an N-point mod-Q NTT core.
// Latency: last input accepted at t -> START t+1 -> ntt_start high t+2 -> first m_valid at t+4 or later.
// Backpressure: s_ready only in LOAD (one vector in flight); DRAIN holds m_data/m_last until m_ready.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   s_valid/s_ready     input coefficient handshake, s_data is reduced mod Q on entry
//   core_a              received vector to the core, element 0 in bits [W-1:0]
//   ntt_start/ntt_done  core handshake; start held through WAIT, done may be sticky
//   core_out            core result, captured when done is trusted
//   m_valid/m_ready     output coefficient handshake, m_data with m_last on element N-1
//   busy                high unless idle in LOAD with nothing buffered
//   timeout             sticky flag for a core that never signalled done
module ntt_stream_adapter #(
  parameter int N        = 8,
  parameter int W        = 8,
  parameter int Q        = 17,
  parameter int WAIT_MAX = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_data,
  output logic [N*W-1:0] core_a,
  output logic           ntt_start,
  input  logic           ntt_done,
  input  logic [N*W-1:0] core_out,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [W-1:0]   m_data,
  output logic           m_last,
  output logic           busy,
  output logic           timeout
);

  localparam int CW  = $clog2(N);
  localparam int WCW = $clog2(WAIT_MAX + 1);

  localparam logic [W-1:0]   QW         = W'(Q);
  localparam logic [CW-1:0]  LAST_IDX   = CW'(N - 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(WAIT_MAX);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0]  ocnt_q, ocnt_d;
  logic           timeout_q, timeout_d;

  logic [W-1:0]   inbuf_q  [N];
  logic [W-1:0]   outbuf_q [N];

  logic           load_en;
  logic           cap_en;
  logic [W-1:0]   s_data_red;

  // Reduction is a plain constant-modulus remainder; the input never needs
  // more than one pass because it is already W bits wide.
  assign s_data_red = s_data % QW;

  // Next-state and control decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    ocnt_d    = ocnt_q;
    timeout_d = timeout_q;
    load_en   = 1'b0;
    cap_en    = 1'b0;

    case (state_q)
      ST_LOAD: begin
        // s_ready is high for the whole of LOAD, so s_valid alone is the handshake.
        if (s_valid) begin
          load_en   = 1'b1;
          timeout_d = 1'b0;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_START: begin
        // One idle cycle with ntt_start low so the core always sees a new rising edge.
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // done seen in the first WAIT cycle may be left over from the previous
        // run, so it is only trusted from wcnt==1 onwards.
        if (ntt_done && (wcnt_q != '0)) begin
          cap_en  = 1'b1;
          wcnt_d  = '0;
          ocnt_d  = '0;
          state_d = ST_DRAIN;
        end else if (wcnt_q == WAIT_LIMIT) begin
          timeout_d = 1'b1;
          wcnt_d    = '0;
          state_d   = ST_LOAD;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end

      ST_DRAIN: begin
        // m_valid is high for the whole of DRAIN, so m_ready alone is the handshake.
        if (m_ready) begin
          if (ocnt_q == LAST_IDX) begin
            ocnt_d  = '0;
            state_d = ST_LOAD;
          end else begin
            ocnt_d = ocnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      ocnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      ocnt_q    <= ocnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Input and output vector buffers. The input buffer is only written in
  // LOAD, which keeps core_a frozen from START until WAIT is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        inbuf_q[i]  <= '0;
        outbuf_q[i] <= '0;
      end
    end else begin
      if (load_en) begin
        inbuf_q[cnt_q] <= s_data_red;
      end
      if (cap_en) begin
        for (int i = 0; i < N; i++) begin
          outbuf_q[i] <= core_out[i*W +: W];
        end
      end
    end
  end

  // Parallel view of the input buffer, element 0 in the low bits
  always_comb begin
    core_a = '0;
    for (int i = 0; i < N; i++) begin
      core_a[i*W +: W] = inbuf_q[i];
    end
  end

  // All outputs decode registered state only; nothing combinational from inputs.
  assign s_ready   = (state_q == ST_LOAD);
  assign ntt_start = (state_q == ST_WAIT);
  assign m_valid   = (state_q == ST_DRAIN);
  // m_data is forced to zero outside DRAIN so a stale buffer never shows on the bus.
  assign m_data    = m_valid ? outbuf_q[ocnt_q] : '0;
  assign m_last    = m_valid && (ocnt_q == LAST_IDX);
  assign busy      = !((state_q == ST_LOAD) && (cnt_q == '0));
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_ntt_stream_adapter.sv
// Purpose: self-checking bench for ntt_stream_adapter with a behavioural mod-17 NTT core model.
// Latency: follows the adapter's load/start/wait/drain sequence one vector at a time.
// Backpressure: drives m_ready always-on, 1,0,0,1 pattern, and random.
module tb_ntt_stream_adapter;

  localparam int N        = 8;
  localparam int W        = 8;
  localparam int Q        = 17;
  localparam int WAIT_MAX = 15;
  localparam int BW       = 6 + W + N*W;

  // {s_ready, ntt_start, m_valid, m_data, m_last, busy, timeout, core_a} after reset
  localparam logic [BW-1:0] RST_VEC = {1'b1, {(BW-1){1'b0}}};

  typedef int vec_t [N];

  logic           clk     = 1'b0;
  logic           rst_n   = 1'b1;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [W-1:0]   s_data  = '0;
  logic [N*W-1:0] core_a;
  logic           ntt_start;
  logic           done_r  = 1'b0;
  logic [N*W-1:0] core_out_r = '0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [W-1:0]   m_data;
  logic           m_last;
  logic           busy;
  logic           timeout;

  int checks = 0;
  int errors = 0;

  // core model controls: 0 = done after a short latency, cleared when start drops
  //                      1 = done sticky forever once set
  //                      2 = never done
  int   core_mode   = 0;
  int   start_rises = 0;
  logic start_prev  = 1'b0;
  int   lat_q       = 0;

  ntt_stream_adapter #(.N(N), .W(W), .Q(Q), .WAIT_MAX(WAIT_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .core_a    (core_a),
    .ntt_start (ntt_start),
    .ntt_done  (done_r),
    .core_out  (core_out_r),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int pow2_mod(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * 2) % Q;
    return r;
  endfunction

  function automatic vec_t ref_reduce(input vec_t v);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = v[i] % Q;
    return r;
  endfunction

  // X[k] = sum_j a[j] * 2^(j*k) mod 17; 2 is a primitive 8th root of unity mod 17
  function automatic vec_t ref_ntt(input vec_t a);
    vec_t r;
    for (int k = 0; k < N; k++) begin
      int s = 0;
      for (int j = 0; j < N; j++) s += a[j] * pow2_mod((j * k) % N);
      r[k] = s % Q;
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] pack(input vec_t v);
    logic [N*W-1:0] p = '0;
    for (int i = 0; i < N; i++) p[i*W +: W] = W'(v[i]);
    return p;
  endfunction

  function automatic vec_t unpack(input logic [N*W-1:0] p);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = int'(p[i*W +: W]);
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = int'($urandom_range(0, 255));
    return r;
  endfunction

  // ---------------- NTT core model ----------------
  always @(posedge clk) begin
    start_prev <= ntt_start;
    if (ntt_start && !start_prev) start_rises <= start_rises + 1;
    case (core_mode)
      0: begin
        if (!ntt_start) begin
          done_r <= 1'b0;
          lat_q  <= 0;
        end else if (!start_prev) begin
          lat_q <= 2;
        end else if (lat_q == 1) begin
          lat_q      <= 0;
          done_r     <= 1'b1;
          core_out_r <= pack(ref_ntt(unpack(core_a)));
        end else if (lat_q > 1) begin
          lat_q <= lat_q - 1;
        end
      end
      1: begin
        if (ntt_start && !start_prev) begin
          done_r     <= 1'b1;
          core_out_r <= pack(ref_ntt(unpack(core_a)));
        end
      end
      default: done_r <= 1'b0;
    endcase
  end

  // ---------------- stimulus tasks ----------------
  // Called at #1 after an edge with the adapter idle in LOAD. Returns in the
  // cycle after the last handshake (START), with junk on s_valid/s_data.
  task automatic do_load(input vec_t v, input bit gaps, output logic tmo_first);
    tmo_first = 1'bx;
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        int idle;
        idle = int'($urandom_range(0, 2));
        for (int g = 0; g < idle; g++) begin
          s_valid = 1'b0;
          s_data  = W'($urandom);
          @(posedge clk); #1;
        end
      end
      checks++;
      if (s_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready beat %0d: s_ready=%b expected 1", i, s_ready);
      end
      s_valid = 1'b1;
      s_data  = W'(v[i]);
      @(posedge clk); #1;
      if (i == 0) tmo_first = timeout;
    end
    s_valid = 1'b1;
    s_data  = W'($urandom);
  endtask

  // Entered in START (cycle t+1). rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic do_drain(input vec_t exp, input logic [N*W-1:0] a_exp, input int rmode, input string nm);
    int beat = 0;
    int cyc = 1;
    int first_v = -1;
    bit hold = 1'b0;
    logic [W-1:0] hd = '0;
    logic hl = 1'b0;
    while (beat < N && cyc < 200) begin
      s_valid = (cyc < 3);
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == 1) begin
        checks++;
        if (s_ready !== 1'b0 || ntt_start !== 1'b0) begin
          errors++;
          $display("FAIL %s start_cycle: s_ready=%b ntt_start=%b expected 0 0", nm, s_ready, ntt_start);
        end
      end
      if (cyc == 2) begin
        checks++;
        if (ntt_start !== 1'b1) begin
          errors++;
          $display("FAIL %s start_rise: ntt_start=%b expected 1", nm, ntt_start);
        end
      end
      if (cyc == 3) begin
        checks++;
        if (core_a !== a_exp) begin
          errors++;
          $display("FAIL %s core_a: got %h expected %h", nm, core_a, a_exp);
        end
      end
      if (m_valid === 1'b1) begin
        if (first_v < 0) begin
          first_v = cyc;
          checks++;
          if (cyc < 4) begin
            errors++;
            $display("FAIL %s latency: first m_valid at t+%0d expected >= t+4", nm, cyc);
          end
        end
        if (hold) begin
          checks++;
          if (m_data !== hd || m_last !== hl) begin
            errors++;
            $display("FAIL %s hold beat %0d: data=%0d last=%b expected %0d %b", nm, beat, m_data, m_last, hd, hl);
          end
        end
        if (m_ready) begin
          checks++;
          if (int'(m_data) !== exp[beat] || m_last !== (beat == N-1)) begin
            errors++;
            $display("FAIL %s beat %0d: data=%0d last=%b expected %0d %b", nm, beat, m_data, m_last, exp[beat], (beat == N-1));
          end
          beat++;
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          hd   = m_data;
          hl   = m_last;
        end
      end else if (hold) begin
        checks++;
        errors++;
        $display("FAIL %s valid_dropped beat %0d: m_valid=%b expected 1", nm, beat, m_valid);
        hold = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (beat < N) begin
      checks++;
      errors++;
      $display("FAIL %s drain_budget: %0d beats expected %0d", nm, beat, N);
    end
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_drain: m_valid=%b s_ready=%b busy=%b expected 0 1 0", nm, m_valid, s_ready, busy);
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s_ready, ntt_start, m_valid, m_data, m_last, busy, timeout, core_a} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", {s_ready, ntt_start, m_valid, m_data, m_last, busy, timeout, core_a}, RST_VEC);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s_ready, ntt_start, m_valid, m_data, m_last, busy, timeout, core_a} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", {s_ready, ntt_start, m_valid, m_data, m_last, busy, timeout, core_a}, RST_VEC);
    end
  endtask

  task automatic test_basic();
    vec_t v;
    logic tf;
    int r0;
    v  = '{1, 2, 3, 4, 5, 6, 7, 8};
    r0 = start_rises;
    do_load(v, 1'b0, tf);
    do_drain(ref_ntt(ref_reduce(v)), pack(ref_reduce(v)), 0, "basic");
    checks++;
    if (start_rises - r0 !== 1) begin
      errors++;
      $display("FAIL basic start_rises: got %0d expected 1", start_rises - r0);
    end
  endtask

  task automatic test_reduce();
    vec_t v;
    vec_t ea;
    logic tf;
    v  = '{17, 34, 255, 16, 0, 18, 100, 200};
    ea = '{0, 0, 0, 16, 0, 1, 15, 13};
    do_load(v, 1'b0, tf);
    do_drain(ref_ntt(ea), pack(ea), 0, "reduce");
  endtask

  task automatic test_backpressure();
    vec_t v;
    logic tf;
    v = rand_vec();
    do_load(v, 1'b1, tf);
    do_drain(ref_ntt(ref_reduce(v)), pack(ref_reduce(v)), 1, "backpressure");
  endtask

  task automatic test_sticky_done();
    vec_t v1;
    vec_t v2;
    logic tf;
    core_mode = 1;
    v1 = rand_vec();
    do_load(v1, 1'b0, tf);
    do_drain(ref_ntt(ref_reduce(v1)), pack(ref_reduce(v1)), 0, "sticky_first");
    v2    = rand_vec();
    v2[0] = (v1[0] % Q + 1) % Q;
    do_load(v2, 1'b0, tf);
    do_drain(ref_ntt(ref_reduce(v2)), pack(ref_reduce(v2)), 2, "sticky_second");
    core_mode = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    vec_t v;
    logic tf;
    int hi = 0;
    int seen_v = 0;
    int cyc = 0;
    core_mode = 2;
    v = rand_vec();
    do_load(v, 1'b0, tf);
    s_valid = 1'b0;
    while (timeout !== 1'b1 && cyc < 60) begin
      m_ready = 1'b1;
      if (ntt_start === 1'b1) hi++;
      if (m_valid !== 1'b0) seen_v++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag: timeout=%b after %0d cycles expected 1", timeout, cyc);
    end
    checks++;
    if (ntt_start !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: ntt_start=%b s_ready=%b m_valid=%b busy=%b expected 0 1 0 0", ntt_start, s_ready, m_valid, busy);
    end
    checks++;
    if (hi < WAIT_MAX || hi > WAIT_MAX + 1) begin
      errors++;
      $display("FAIL timeout_wait_len: ntt_start high %0d cycles expected %0d..%0d", hi, WAIT_MAX, WAIT_MAX + 1);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (m_valid !== 1'b0) seen_v++;
    end
    checks++;
    if (seen_v !== 0) begin
      errors++;
      $display("FAIL timeout_no_output: m_valid seen %0d cycles expected 0", seen_v);
    end
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: timeout=%b expected 1", timeout);
    end
    m_ready   = 1'b0;
    core_mode = 0;
    v = rand_vec();
    do_load(v, 1'b1, tf);
    checks++;
    if (tf !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: timeout=%b after first accepted input expected 0", tf);
    end
    do_drain(ref_ntt(ref_reduce(v)), pack(ref_reduce(v)), 0, "after_timeout");
  endtask

  task automatic test_reset_midload();
    vec_t v;
    logic tf;
    v = rand_vec();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = W'(v[i]);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midload_busy: busy=%b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, ntt_start, m_valid, m_data, m_last, busy, timeout, core_a} !== RST_VEC) begin
      errors++;
      $display("FAIL midload_reset: got %h expected %h", {s_ready, ntt_start, m_valid, m_data, m_last, busy, timeout, core_a}, RST_VEC);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = rand_vec();
    do_load(v, 1'b0, tf);
    do_drain(ref_ntt(ref_reduce(v)), pack(ref_reduce(v)), 2, "after_midload_reset");
  endtask

  task automatic test_reset_drain();
    vec_t v;
    vec_t ex;
    logic tf;
    int beat = 0;
    int cyc = 0;
    bit hit = 1'b0;
    v  = rand_vec();
    ex = ref_ntt(ref_reduce(v));
    do_load(v, 1'b0, tf);
    s_valid = 1'b0;
    while (!hit && cyc < 60) begin
      m_ready = 1'b1;
      if (m_valid === 1'b1) begin
        if (beat == 3) begin
          rst_n = 1'b0;
          #1;
          hit = 1'b1;
          checks++;
          if ({s_ready, ntt_start, m_valid, m_data, m_last, busy, timeout, core_a} !== RST_VEC) begin
            errors++;
            $display("FAIL drain_reset: got %h expected %h", {s_ready, ntt_start, m_valid, m_data, m_last, busy, timeout, core_a}, RST_VEC);
          end
        end else begin
          checks++;
          if (int'(m_data) !== ex[beat]) begin
            errors++;
            $display("FAIL drain_reset beat %0d: data=%0d expected %0d", beat, m_data, ex[beat]);
          end
          beat++;
        end
      end
      if (!hit) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL drain_reset_budget: reached beat %0d expected 3", beat);
    end
    m_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = rand_vec();
    do_load(v, 1'b1, tf);
    do_drain(ref_ntt(ref_reduce(v)), pack(ref_reduce(v)), 0, "after_drain_reset");
  endtask

  task automatic test_random();
    vec_t v;
    logic tf;
    for (int n = 0; n < 5; n++) begin
      v = rand_vec();
      do_load(v, 1'b1, tf);
      do_drain(ref_ntt(ref_reduce(v)), pack(ref_reduce(v)), 2, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reduce();
    test_backpressure();
    test_sticky_done();
    test_timeout();
    test_reset_midload();
    test_reset_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_stream_adapter.md
Name: ntt_stream_adapter

Overview:
- Sequential front/back-end for the combinational-style 8-point NTT core (mod-17 arithmetic).
- Accepts coefficients one per cycle over a valid/ready stream and reduces each mod Q.
- Presents the full vector in parallel to the core, drives its start, and waits for done.
- Captures the transformed vector and streams it out one coefficient per cycle.

Parameters:
- N, 8, number of coefficients per transform (power of two, ≥2)
- W, 8, coefficient width in bits
- Q, 17, modulus; all coefficients are reduced into [0, Q-1]
- WAIT_MAX, 15, maximum cycles to wait for core done before flagging timeout

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input coefficient valid
- s_ready  out  1  adapter can accept an input coefficient
- s_data  in  W  input coefficient (unreduced)
- core_a  out  N×W  parallel vector to NTT core (index 0 = first received)
- ntt_start  out  1  start to NTT core
- ntt_done  in  1  done from NTT core
- core_out  in  N×W  parallel result from NTT core
- m_valid  out  1  output coefficient valid
- m_ready  in  1  downstream accepts output coefficient
- m_data  out  W  output coefficient
- m_last  out  1  high with the final (index N-1) output coefficient
- busy  out  1  high in any state other than LOAD with count 0
- timeout  out  1  sticky; set on done timeout, cleared by reset or next accepted input

Behaviour:
- Reset (async, rst_n=0) values:
  - state=LOAD, counters=0, buffers=0, core_a=0.
  - s_ready=1, ntt_start=0, m_valid=0, m_data=0, m_last=0, busy=0, timeout=0.
- FSM states: LOAD → START → WAIT → DRAIN → LOAD.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready, buffer[cnt] ← s_data mod Q and cnt increments.
  - Reduction is purely combinational (e.g. 8-bit: 255 → 0, 17 → 0, 16 → 16, 34 → 0).
  - When the N-th coefficient is accepted, cnt wraps to 0 and the next state is START.
  - s_ready drops the following cycle; no input is accepted outside LOAD.
- START:
  - One cycle with ntt_start=0, guaranteeing the core sees a fresh rising edge.
  - core_a is stable from this cycle until leaving WAIT.
- WAIT:
  - ntt_start=1 held; wait counter wcnt increments from 0.
  - ntt_done is sampled only when wcnt≥1, because core done may be sticky from a previous run.
  - ntt_done=1 with wcnt≥1: capture core_out into the output buffer, deassert ntt_start next cycle, go to DRAIN.
  - wcnt reaches WAIT_MAX without done: set timeout=1, deassert ntt_start, return to LOAD with the output buffer unchanged; no output is emitted.
- DRAIN:
  - m_valid=1; m_data=outbuf[ocnt]; m_last=(ocnt==N-1).
  - ocnt advances only on m_valid&&m_ready.
  - m_data/m_last hold stable while m_ready=0 (no data change under backpressure).
  - After the handshake with m_last, go to LOAD; m_valid=0 next cycle.
- Latency: last input accepted at cycle t → START at t+1 → ntt_start rises at t+2 → first m_valid no earlier than t+4.
- Throughput: no overlap; a new vector is accepted only after the previous vector has fully drained.
- Simultaneous events:
  - s_valid during START/WAIT/DRAIN is ignored (s_ready=0).
  - m_ready held high drains one coefficient per cycle.
- Reset mid-operation: immediate return to reset values.
  - Partial load is discarded.
  - ntt_start drops asynchronously.
  - A pending output is lost.
- Outputs are registered; s_ready and m_valid are functions of state only.

Test Plan:
- Load 1,2,3,4,5,6,7,8 with s_valid continuous; core model returns 36 mod 17 = 2 at index 0 → exactly one ntt_start rising edge; m_data sequence matches core_out; m_last only on the 8th beat.
- Load 17,34,255,16,0,18,100,200 → core_a = 0,0,0,16,0,1,15,13.
- Drain with m_ready toggling 1,0,0,1 per cycle → each m_data held while m_ready=0; exactly 8 handshakes with no duplicates or skips.
- Core model holds ntt_done=1 permanently from a previous run → adapter waits at least 1 cycle after start before capture; second vector's output reflects the new core_out, not stale data.
- Core never asserts done → after WAIT_MAX=15 cycles timeout=1, ntt_start=0, m_valid never rises; next accepted input clears timeout.
- Assert rst_n=0 after 5 coefficients, and separately during DRAIN at ocnt=3 → all outputs return to reset values immediately; a subsequent full 8-coefficient load operates normally.
